regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised general-purpose register file with 2 combinational read ports, 1 synchronous write port and a per-register pending scoreboard. It sits between instruction decode and writeback in the single-cycle/multi-cycle datapath. It generalises the 4x8-bit file to N x W and adds an optional hard-wired zero register, write-to-read bypass, and RAW/WAW hazard detection for multi-cycle writebacks.

Parameters:
DATA_W, 8, register width in bits
NUM_REGS, 4, register count (power of 2, >=2)
ADDR_W, $clog2(NUM_REGS), register address width (derived)
ZERO_REG, 0, 1 = register 0 reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  read port A data (combinational)
rd_data_b  out  DATA_W  read port B data (combinational)
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
issue_en  in  1  decode requests issue of an instruction writing issue_dst
issue_dst  in  ADDR_W  destination register of issuing instruction
flush  in  1  synchronous clear of all pending bits (data untouched)
hazard  out  1  issue must stall (combinational)
issue_ack  out  1  issue_en && !hazard (combinational)
pending_cnt  out  ADDR_W+1  number of registers currently pending (registered)

Behaviour:
- Reset (async, rst=1): all registers <= 0, pending[] <= 0, pending_cnt <= 0. Reads during reset return 0 (no bypass while rst).
- Write: at posedge clk with wr_en=1, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0. ZERO_REG=1 and wr_addr=0: no effect.
- Read: rd_data_x = reg[rd_addr_x]; ZERO_REG=1 and addr=0 -> 0. BYPASS=1 and wr_en && wr_addr==rd_addr_x (not the zero reg) -> wr_data. BYPASS=0 -> old value until the next edge.
- Effective pending: eff_p[r] = pending[r] && !(wr_en && wr_addr==r && BYPASS). With BYPASS=0, pending is honoured until the edge.
- hazard = issue_en && (eff_p[rd_addr_a] || eff_p[rd_addr_b] || eff_p[issue_dst]). The check covers RAW on both sources and WAW on the destination. hazard=0 when issue_en=0.
- Issue: at posedge with issue_ack=1 and issue_dst not the zero reg, pending[issue_dst] <= 1. Latency 1 cycle to hazard visibility.
- Same-edge write and issue to the same register: issue wins (pending ends 1, data updated).
- flush at posedge: all pending <= 0 and overrides same-edge issue. A same-edge write still updates data.
- pending_cnt: registered popcount of the next pending vector. It equals the population of pending[] every cycle and never exceeds NUM_REGS (NUM_REGS-1 if ZERO_REG).
- Unknown/out-of-range addresses cannot occur (power-of-2 depth). Wrap-around is not applicable.

Decomposition:
- Shared package cpu_pkg: DATA_W/NUM_REGS defaults, reg address typedef, instruction field positions for ra/rb (inst[11:10], inst[9:8] in the 4-reg config) so decode derives rd_addr/issue_dst consistently.
- One sub-module: sb_popcount (parametrised popcount of the NUM_REGS pending vector) feeding pending_cnt.
- Storage array, bypass muxes and hazard logic stay in regfile_sb.

Test Plan:
- Reset mid-operation: write R2=0x5A, set pending R1, assert rst asynchronously between edges -> rd_data R2=0x00 immediately, pending_cnt=0, hazard=0.
- Write/read and bypass (BYPASS=1): wr_en R3=0xC3 with rd_addr_a=3 in the same cycle -> rd_data_a=0xC3 before the edge. With BYPASS=0 -> old 0x00 until the edge, then 0xC3.
- RAW stall: issue dst=R1 (ack), next cycle issue with rd_addr_b=1 -> hazard=1, issue_ack=0. Stall holds until wr_en R1=0x11. In that cycle hazard=0 (BYPASS=1) and rd_data_b=0x11.
- WAW plus same-edge write/issue: pending R2, then the same cycle wr_en R2=0x22 and issue dst=R2 -> after the edge reg R2=0x22, pending[2]=1, pending_cnt=1.
- ZERO_REG=1: wr_en R0=0xFF, issue dst=R0 -> rd R0=0x00, pending_cnt unchanged, hazard never asserted for R0 sources.
- Flush: pending R1,R2,R3 (pending_cnt=3), flush with simultaneous issue dst=R1 -> pending_cnt=0, all subsequent issues acked.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared register-file definitions: default geometry, the register address type,
// and where the source register fields sit in an instruction word.
package regfile_sb_pkg;

  localparam int RF_DATA_W   = 8;
  localparam int RF_NUM_REGS = 4;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;

  // Source fields for the 4-register configuration: ra = inst[11:10], rb = inst[9:8]
  localparam int INST_W      = 16;
  localparam int INST_RA_LSB = 10;
  localparam int INST_RB_LSB = 8;

  function automatic reg_addr_t inst_ra(input logic [INST_W-1:0] inst);
    return inst[INST_RA_LSB +: RF_ADDR_W];
  endfunction

  function automatic reg_addr_t inst_rb(input logic [INST_W-1:0] inst);
    return inst[INST_RB_LSB +: RF_ADDR_W];
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of read, writeback and issue/scoreboard signals between decode,
// writeback and the register file.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_dst;
  logic              flush;
  logic              hazard;
  logic              issue_ack;
  logic [ADDR_W:0]   pending_cnt;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
           issue_en, issue_dst, flush,
    input  rd_data_a, rd_data_b, hazard, issue_ack, pending_cnt
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
           issue_en, issue_dst, flush,
    output rd_data_a, rd_data_b, hazard, issue_ack, pending_cnt
  );

endinterface

// File: rtl/regfile_sb_popcount.sv
// Population count of the scoreboard pending vector.
module sb_popcount #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic [N-1:0]     vec_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + CNT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// N x W register file with two combinational reads, one synchronous write,
// optional zero register / write bypass, and a pending-writeback scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_sb_if.slave   rf
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] eff_p;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     cnt_d;
  logic                wr_eff;
  logic                iss_eff;
  logic                byp_a;
  logic                byp_b;
  logic                hazard;
  logic                ack;

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              hit,
    input logic [DATA_W-1:0] wdata
  );
    if (ZR && addr == '0) return '0;
    if (hit)              return wdata;
    return stored;
  endfunction

  // Writes to a hard-wired zero register are dropped entirely
  assign wr_eff = rf.wr_en && !(ZR && rf.wr_addr == '0);

  // Bypass is suppressed under reset so reads return the cleared array
  assign byp_a = BP && !rst && wr_eff && (rf.wr_addr == rf.rd_addr_a);
  assign byp_b = BP && !rst && wr_eff && (rf.wr_addr == rf.rd_addr_b);

  assign rf.rd_data_a = rd_sel(rf.rd_addr_a, regs_q[rf.rd_addr_a], byp_a, rf.wr_data);
  assign rf.rd_data_b = rd_sel(rf.rd_addr_b, regs_q[rf.rd_addr_b], byp_b, rf.wr_data);

  // A writeback landing this cycle already satisfies its consumer when bypassed
  always_comb begin
    eff_p = pending_q;
    if (BP && wr_eff) eff_p[rf.wr_addr] = 1'b0;
  end

  assign hazard = rf.issue_en &&
                  (eff_p[rf.rd_addr_a] || eff_p[rf.rd_addr_b] || eff_p[rf.issue_dst]);
  assign ack     = rf.issue_en && !hazard;
  assign iss_eff = ack && !(ZR && rf.issue_dst == '0);

  assign rf.hazard      = hazard;
  assign rf.issue_ack   = ack;
  assign rf.pending_cnt = cnt_q;

  // Priority: writeback clear, then issue set, then flush clears everything
  always_comb begin
    pending_d = pending_q;
    if (wr_eff)   pending_d[rf.wr_addr]   = 1'b0;
    if (iss_eff)  pending_d[rf.issue_dst] = 1'b1;
    if (rf.flush) pending_d = '0;
    if (ZR)       pending_d[0] = 1'b0;
  end

  sb_popcount #(
    .N     (NUM_REGS),
    .CNT_W (ADDR_W + 1)
  ) u_popcount (
    .vec_i (pending_d),
    .cnt_o (cnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_eff) begin
      regs_q[rf.wr_addr] <= rf.wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a plain file (no zero reg, bypass on) driven from a vector
// table through a scoreboard queue, plus a zero-reg / no-bypass instance.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(8), .ADDR_W(2)) if0 ();
  regfile_sb_if #(.DATA_W(8), .ADDR_W(2)) if1 ();

  regfile_sb #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(0), .BYPASS(1)) u0 (
    .clk (clk), .rst (rst), .rf (if0)
  );
  regfile_sb #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk (clk), .rst (rst), .rf (if1)
  );

  typedef struct {
    logic       we;  logic [1:0] wa;  logic [7:0] wd;
    logic [1:0] ra;  logic [1:0] rb;
    logic       ie;  logic [1:0] dst; logic       fl;
    logic [7:0] ea;  logic [7:0] eb;
    logic       ehz; logic       eack; logic [2:0] ecnt;
  } vec_t;

  typedef struct {
    int idx;
    logic [7:0] a; logic [7:0] b; logic hz; logic ack; logic [2:0] cnt;
  } exp_t;

  localparam int NV = 18;
  vec_t vt [NV];
  exp_t sbq [$];
  exp_t e;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  task automatic idle0();
    if0.wr_en = 0; if0.wr_addr = 0; if0.wr_data = 0;
    if0.rd_addr_a = 0; if0.rd_addr_b = 0;
    if0.issue_en = 0; if0.issue_dst = 0; if0.flush = 0;
  endtask

  task automatic idle1();
    if1.wr_en = 0; if1.wr_addr = 0; if1.wr_data = 0;
    if1.rd_addr_a = 0; if1.rd_addr_b = 0;
    if1.issue_en = 0; if1.issue_dst = 0; if1.flush = 0;
  endtask

  initial begin
    //           we wa  wd     ra rb ie dst fl  ea     eb     hz ack cnt
    vt[0]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 3'd0};
    vt[1]  = '{1, 3, 8'hC3, 3, 0, 0, 0, 0, 8'hC3, 8'h00, 0, 0, 3'd0};
    vt[2]  = '{0, 0, 8'h00, 3, 3, 0, 0, 0, 8'hC3, 8'hC3, 0, 0, 3'd0};
    vt[3]  = '{0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1, 3'd1};
    vt[4]  = '{0, 0, 8'h00, 0, 1, 1, 2, 0, 8'h00, 8'h00, 1, 0, 3'd1};
    vt[5]  = '{0, 0, 8'h00, 0, 1, 1, 2, 0, 8'h00, 8'h00, 1, 0, 3'd1};
    vt[6]  = '{1, 1, 8'h11, 0, 1, 1, 2, 0, 8'h00, 8'h11, 0, 1, 3'd1};
    vt[7]  = '{0, 0, 8'h00, 3, 3, 1, 2, 0, 8'hC3, 8'hC3, 1, 0, 3'd1};
    vt[8]  = '{1, 2, 8'h22, 2, 1, 1, 2, 0, 8'h22, 8'h11, 0, 1, 3'd1};
    vt[9]  = '{0, 0, 8'h00, 2, 0, 0, 0, 0, 8'h22, 8'h00, 0, 0, 3'd1};
    vt[10] = '{0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1, 3'd2};
    vt[11] = '{0, 0, 8'h00, 0, 0, 1, 3, 0, 8'h00, 8'h00, 0, 1, 3'd3};
    vt[12] = '{0, 0, 8'h00, 0, 0, 1, 1, 1, 8'h00, 8'h00, 1, 0, 3'd0};
    vt[13] = '{0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h00, 8'h00, 0, 1, 3'd0};
    vt[14] = '{0, 0, 8'h00, 2, 3, 1, 1, 0, 8'h22, 8'hC3, 0, 1, 3'd1};
    vt[15] = '{0, 0, 8'h00, 0, 0, 1, 2, 0, 8'h00, 8'h00, 0, 1, 3'd2};
    vt[16] = '{1, 0, 8'h77, 0, 2, 0, 0, 1, 8'h77, 8'h22, 0, 0, 3'd0};
    vt[17] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h77, 8'h11, 0, 0, 3'd0};

    rst = 1'b1;
    idle0();
    idle1();
    #12;
    chk("rst_cnt0", if0.pending_cnt, 0);
    chk("rst_rd0", if0.rd_data_a, 0);
    chk("rst_cnt1", if1.pending_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if0.wr_en = vt[i].we; if0.wr_addr = vt[i].wa; if0.wr_data = vt[i].wd;
      if0.rd_addr_a = vt[i].ra; if0.rd_addr_b = vt[i].rb;
      if0.issue_en = vt[i].ie; if0.issue_dst = vt[i].dst; if0.flush = vt[i].fl;
      sbq.push_back('{i, vt[i].ea, vt[i].eb, vt[i].ehz, vt[i].eack, vt[i].ecnt});
      #2;
      e = sbq.pop_front();
      chk($sformatf("v%0d_rd_a", e.idx), if0.rd_data_a, e.a);
      chk($sformatf("v%0d_rd_b", e.idx), if0.rd_data_b, e.b);
      chk($sformatf("v%0d_hazard", e.idx), if0.hazard, e.hz);
      chk($sformatf("v%0d_ack", e.idx), if0.issue_ack, e.ack);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cnt", e.idx), if0.pending_cnt, e.cnt);
    end

    // Asynchronous reset in the middle of a cycle
    @(negedge clk);
    idle0();
    if0.wr_en = 1; if0.wr_addr = 2; if0.wr_data = 8'h5A;
    if0.issue_en = 1; if0.issue_dst = 1;
    @(posedge clk);
    #1;
    chk("pre_rst_cnt", if0.pending_cnt, 1);
    idle0();
    if0.rd_addr_a = 2; if0.rd_addr_b = 1; if0.issue_en = 1; if0.issue_dst = 3;
    #1;
    chk("pre_rst_rd", if0.rd_data_a, 8'h5A);
    chk("pre_rst_hz", if0.hazard, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_rd", if0.rd_data_a, 0);
    chk("async_rst_cnt", if0.pending_cnt, 0);
    chk("async_rst_hz", if0.hazard, 0);
    if0.wr_en = 1; if0.wr_addr = 2; if0.wr_data = 8'h33;
    #1;
    chk("rst_no_bypass", if0.rd_data_a, 0);
    @(negedge clk);
    rst = 1'b0;
    idle0();
    if0.rd_addr_a = 2;
    #1;
    chk("post_rst_rd", if0.rd_data_a, 0);

    // No bypass: old data until the edge
    @(negedge clk);
    idle1();
    if1.wr_en = 1; if1.wr_addr = 3; if1.wr_data = 8'hC3; if1.rd_addr_a = 3;
    #2;
    chk("nobyp_old", if1.rd_data_a, 0);
    @(posedge clk);
    #1;
    chk("nobyp_new", if1.rd_data_a, 8'hC3);

    // Zero register ignores writes and never goes pending
    @(negedge clk);
    idle1();
    if1.wr_en = 1; if1.wr_addr = 0; if1.wr_data = 8'hFF;
    if1.issue_en = 1; if1.issue_dst = 0;
    #2;
    chk("zr_rd_byp", if1.rd_data_a, 0);
    chk("zr_ack", if1.issue_ack, 1);
    @(posedge clk);
    #1;
    chk("zr_cnt", if1.pending_cnt, 0);
    chk("zr_rd", if1.rd_data_a, 0);

    @(negedge clk);
    idle1();
    if1.issue_en = 1; if1.issue_dst = 1;
    #2;
    chk("zr_iss1_ack", if1.issue_ack, 1);
    @(posedge clk);
    #1;
    chk("zr_iss1_cnt", if1.pending_cnt, 1);

    // Without bypass, a same-cycle writeback does not release the stall
    @(negedge clk);
    idle1();
    if1.wr_en = 1; if1.wr_addr = 1; if1.wr_data = 8'hAA;
    if1.issue_en = 1; if1.issue_dst = 2; if1.rd_addr_a = 1;
    #2;
    chk("nobyp_hz", if1.hazard, 1);
    chk("nobyp_ack", if1.issue_ack, 0);
    chk("nobyp_rd_old", if1.rd_data_a, 0);
    @(posedge clk);
    #1;
    chk("nobyp_cnt", if1.pending_cnt, 0);
    chk("nobyp_rd_new", if1.rd_data_a, 8'hAA);

    @(negedge clk);
    idle1();
    if1.issue_en = 1; if1.issue_dst = 0;
    #2;
    chk("zr_src_hz", if1.hazard, 0);

    @(negedge clk);
    idle0();
    idle1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
